// File: rtl/alu_seq_if.sv
// Handshake and data bundle between the operand source, alu_seq and the
// result consumer.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       func_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_hi;
    logic             ov_sgn;
    logic             zero;

    // Operand source and result consumer side.
    modport master (
        output in_valid, a, b, func_sel, out_ready,
        input  in_ready, out_valid, r, r_hi, ov_sgn, zero
    );

    // ALU side.
    modport slave (
        input  in_valid, a, b, func_sel, out_ready,
        output in_ready, out_valid, r, r_hi, ov_sgn, zero
    );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete at the accept edge; unsigned multiply runs as a
// WIDTH-step shift-add sequence and stalls the input while busy.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state, next_state;

    logic               out_valid_q;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_hi_q;
    logic               ov_q;
    logic               zero_q;

    // Multiplier: acc holds {partial high half, remaining multiplier bits}.
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               in_ready_i;
    logic               accept;
    logic               consume;
    logic               mul_op;

    logic [WIDTH:0]     sum;
    logic [SW-1:0]      rot_n;
    logic [2*WIDTH-1:0] rot_buf;
    logic [WIDTH-1:0]   op_r;
    logic               op_ov;

    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] acc_step;

    assign in_ready_i = !rst && (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_i;
    assign consume    = out_valid_q && bus.out_ready;
    assign mul_op     = (bus.func_sel == 4'b1000);
    assign rot_n      = SW'(32'(bus.b[SW-1:0]) % WIDTH);

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.r_hi      = r_hi_q;
    assign bus.ov_sgn    = ov_q;
    assign bus.zero      = zero_q;

    // Single-cycle operation result and flag.
    always_comb begin
        op_r    = '0;
        op_ov   = 1'b0;
        rot_buf = '0;
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        case (bus.func_sel[2:0])
            3'b000: begin
                op_r  = sum[WIDTH-1:0];
                op_ov = sum[WIDTH];
            end
            3'b001: begin
                op_r  = bus.a - bus.b;
                op_ov = (bus.a < bus.b);
            end
            3'b010: begin
                op_r[0] = (bus.a == bus.b);
                op_r[1] = (bus.a > bus.b);
                op_ov   = (bus.a < bus.b);
            end
            3'b011: op_r = ~bus.a + WIDTH'(1);
            3'b100: op_r = bus.a & bus.b;
            3'b101: op_r = bus.a | bus.b;
            3'b110: op_r = bus.a ^ bus.b;
            3'b111: begin
                // Rotation via a doubled operand: shifting {a,a} wraps bits around.
                if (bus.func_sel[3]) begin
                    rot_buf = {bus.a, bus.a} >> rot_n;
                    op_r    = rot_buf[WIDTH-1:0];
                end else begin
                    rot_buf = {bus.a, bus.a} << rot_n;
                    op_r    = rot_buf[2*WIDTH-1:WIDTH];
                end
            end
            default: op_r = '0;
        endcase
    end

    // One shift-add step: conditionally add multiplicand to the high half, shift right.
    always_comb begin
        hi_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {hi_sum, acc[WIDTH-1:1]};
    end

    // Next-state logic: leave IDLE only on an accepted multiply.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && mul_op) next_state = MUL;
            MUL:     if (cnt == CNT_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Result registers, output valid and multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
            r_hi_q      <= '0;
            ov_q        <= 1'b0;
            zero_q      <= 1'b0;
            mcand       <= '0;
            acc         <= '0;
            cnt         <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                if (mul_op) begin
                    mcand       <= bus.a;
                    acc         <= {{WIDTH{1'b0}}, bus.b};
                    cnt         <= '0;
                    out_valid_q <= 1'b0;
                end else begin
                    r_q         <= op_r;
                    r_hi_q      <= '0;
                    ov_q        <= op_ov;
                    zero_q      <= (op_r == '0);
                    out_valid_q <= 1'b1;
                end
            end else if (consume) begin
                out_valid_q <= 1'b0;
            end
        end else begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
            // The final step's result is published directly so the product
            // appears exactly WIDTH edges after acceptance.
            if (cnt == CNT_LAST) begin
                r_q         <= acc_step[WIDTH-1:0];
                r_hi_q      <= acc_step[2*WIDTH-1:WIDTH];
                ov_q        <= (acc_step[2*WIDTH-1:WIDTH] != '0);
                zero_q      <= (acc_step == '0);
                out_valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the combinational 4-bit ALU; same operation set generalised to WIDTH bits.
- Adds a valid/ready handshake on input and output, a barrel rotate by a variable amount, and a multi-cycle unsigned shift-add multiplier.
- Sits between an operand source and a result consumer in the datapath; single-cycle ops run at full throughput, multiply stalls the input.

Parameters:
- WIDTH, 8, operand/result width in bits (WIDTH >= 2; SW = $clog2(WIDTH)).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned; rotate amount = b[SW-1:0] mod WIDTH)
- func_sel  input  4  [2:0] opcode, [3] mode bit
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  consumer takes result this cycle
- r  output  WIDTH  result (low half for multiply)
- r_hi  output  WIDTH  multiply high half; 0 for all other ops
- ov_sgn  output  1  overflow / sign flag (per opcode)
- zero  output  1  full result (r_hi,r) == 0

Behaviour:
- Reset (rst=1 at an edge): state IDLE, out_valid=0, r=0, r_hi=0, ov_sgn=0, zero=0, multiplier regs cleared. in_ready=0 while rst is high. Reset mid-multiply aborts it; no result is produced.
- Opcodes (func_sel[2:0]), all unsigned:
  - 000 add: r=(a+b) mod 2^WIDTH, ov_sgn=carry out. With func_sel[3]=1: multiply (see below).
  - 001 sub: r=(a-b) mod 2^WIDTH, ov_sgn=1 iff a<b.
  - 010 compare: r[0]=(a==b), r[1]=(a>b), other bits 0; ov_sgn=(a<b).
  - 011 negate: r=(~a+1) mod 2^WIDTH, b ignored, ov_sgn=0.
  - 100 AND, 101 OR, 110 XOR: bitwise; ov_sgn=0.
  - 111 rotate a by n=b[SW-1:0] mod WIDTH: func_sel[3]=1 right, 0 left; n=0 gives r=a; ov_sgn=0.
  - func_sel[3] is ignored for opcodes 001-110.
- Handshake:
  - in_ready = !rst && state==IDLE && (!out_valid || out_ready).
  - An operation is accepted at an edge where in_valid && in_ready.
  - The result is consumed at an edge where out_valid && out_ready.
  - Accept and consume in the same cycle are legal: the old result retires and the new one loads. Single-cycle ops sustain 1 op/cycle.
  - While out_valid && !out_ready, r/r_hi/ov_sgn/zero are held stable and no op is accepted.
- Single-cycle ops: result registers load at the accept edge; out_valid=1 from that edge (latency 1).
- Multiply (func_sel=4'b1000):
  - Accept edge: latch a, b; clear the product accumulator; counter=0; state IDLE->MUL.
  - MUL: one shift-add step per cycle (test multiplier LSB, add multiplicand to upper accumulator, shift right). Counter increments each step.
  - After WIDTH steps, load {r_hi,r}=a*b, ov_sgn=(r_hi!=0), out_valid=1; state MUL->IDLE. out_valid rises exactly WIDTH edges after the accept edge.
  - in_ready=0 throughout MUL.
  - out_valid is always 0 when MUL is entered, because accept requires an empty or retiring output.
- zero: asserted iff {r_hi,r}==0 for the current result; for compare it reflects r only.
- Inputs are ignored unless accepted. Changing a/b during MUL has no effect.
- out_valid drops at the consume edge unless a new op is accepted on that same edge.

Test Plan:
- WIDTH=8, add a=200 b=100, out_ready=1 -> next cycle out_valid=1, r=44, ov_sgn=1, zero=0; then sub a=5 b=9 -> r=252, ov_sgn=1.
- Compare a=7 b=7 -> r=1, ov_sgn=0; compare a=3 b=9 -> r=0, ov_sgn=1, zero=1.
- Rotate a=0x81: func_sel=4'b1111, b=1 -> r=0xC0; func_sel=4'b0111, b=3 -> r=0x0C; b=8 -> r=0x81.
- Multiply a=255 b=255 -> in_ready=0 for 8 cycles; out_valid exactly 8 edges after accept; r=0x01, r_hi=0xFE, ov_sgn=1. Multiply 0*200 -> zero=1, ov_sgn=0.
- Backpressure: XOR result with out_ready=0 for 5 cycles -> r held, in_ready=0, second op stalls. Raise out_ready with in_valid=1 -> consume and accept on the same edge; back-to-back ops reach 1/cycle.
- Assert rst 3 cycles into a multiply -> out_valid never rises, all outputs 0. in_ready=1 one cycle after rst deasserts.
